// File: rtl/alu_operand_stage_if.sv
// Handshake and data bundle for the ALU operand-select stage.
// master = upstream/consumer side that drives the selection and out_ready; slave = the stage.
interface alu_operand_stage_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [DATA_W-1:0]         imm_ext;
    logic [SEL_W-1:0]          a_sel;
    logic [SEL_W-1:0]          b_sel;
    logic                      b_imm_en;
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         op_a;
    logic [DATA_W-1:0]         op_b;
    logic                      sel_err;
    logic [1:0]                occupancy;

    modport master (
        output src_data, imm_ext, a_sel, b_sel, b_imm_en, in_valid, flush, out_ready,
        input  in_ready, out_valid, op_a, op_b, sel_err, occupancy
    );

    modport slave (
        input  src_data, imm_ext, a_sel, b_sel, b_imm_en, in_valid, flush, out_ready,
        output in_ready, out_valid, op_a, op_b, sel_err, occupancy
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered operand-select stage: picks A/B from NUM_SRC sources (B may take the
// immediate) and holds the pair in a 2-entry skid buffer with valid/ready on both sides.
module alu_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_stage_if.slave   bus
);
    localparam int SEL_W = $clog2(NUM_SRC);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;

    entry_t in_entry;
    logic   a_err, b_err;
    logic   accept, pop;

    // An unmatched select leaves the operand at zero and flags the entry.
    always_comb begin
        in_entry = '0;
        a_err    = 1'b1;
        b_err    = 1'b1;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.a_sel == SEL_W'(i)) begin
                in_entry.a = bus.src_data[i*DATA_W +: DATA_W];
                a_err      = 1'b0;
            end
            if (bus.b_sel == SEL_W'(i)) begin
                in_entry.b = bus.src_data[i*DATA_W +: DATA_W];
                b_err      = 1'b0;
            end
        end
        if (bus.b_imm_en) begin
            in_entry.b = bus.imm_ext;
            b_err      = 1'b0;
        end
        in_entry.err = a_err | b_err;
    end

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = out_valid_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any concurrent accept; stale data may stay in the registers.
        if (bus.flush) begin
            state_d = EMPTY;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.op_a      = main_q.a;
    assign bus.op_b      = main_q.b;
    assign bus.sel_err   = main_q.err;
    assign bus.occupancy = state_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, back-pressure/stream/flush/reset
// sequences, and a per-instance scoreboard fed at accept and drained at pop.
module tb_alu_operand_stage;
    logic clk;
    logic rst_n;

    alu_operand_stage_if #(.DATA_W(32), .NUM_SRC(4)) if4 ();
    alu_operand_stage_if #(.DATA_W(32), .NUM_SRC(3)) if3 ();

    alu_operand_stage #(.DATA_W(32), .NUM_SRC(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    alu_operand_stage #(.DATA_W(32), .NUM_SRC(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        err;
    } exp_t;

    typedef struct {
        int          dut;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic        b_imm_en;
        logic [31:0] imm;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int pops4   = 0;
    exp_t q4[$];
    exp_t q3[$];
    exp_t e4, e3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [127:0] src, input logic [31:0] imm,
                                   input logic [1:0] asel, input logic [1:0] bsel,
                                   input logic bimm, input int nsrc);
        exp_t r;
        int ai = int'(asel);
        int bi = int'(bsel);
        r.a   = (ai < nsrc) ? src[ai*32 +: 32] : 32'h0;
        r.b   = bimm ? imm : ((bi < nsrc) ? src[bi*32 +: 32] : 32'h0);
        r.err = (ai >= nsrc) || (!bimm && bi >= nsrc);
        return r;
    endfunction

    // Scoreboards: sample at negedge, where the handshake for the coming edge is settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            q4.delete();
        end else begin
            if (!if4.flush && if4.out_valid && if4.out_ready) begin
                if (q4.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb4_extra: actual output %0h/%0h required none", if4.op_a, if4.op_b);
                end else begin
                    e4 = q4.pop_front();
                    check("sb4_op_a", {32'h0, if4.op_a}, {32'h0, e4.a});
                    check("sb4_op_b", {32'h0, if4.op_b}, {32'h0, e4.b});
                    check("sb4_err", {63'h0, if4.sel_err}, {63'h0, e4.err});
                    pops4++;
                end
            end
            if (!if4.flush && if4.in_valid && if4.in_ready)
                q4.push_back(model(if4.src_data, if4.imm_ext, if4.a_sel, if4.b_sel, if4.b_imm_en, 4));
            if (if4.flush) q4.delete();
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q3.delete();
        end else begin
            if (!if3.flush && if3.out_valid && if3.out_ready) begin
                if (q3.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb3_extra: actual output %0h/%0h required none", if3.op_a, if3.op_b);
                end else begin
                    e3 = q3.pop_front();
                    check("sb3_op_a", {32'h0, if3.op_a}, {32'h0, e3.a});
                    check("sb3_op_b", {32'h0, if3.op_b}, {32'h0, e3.b});
                    check("sb3_err", {63'h0, if3.sel_err}, {63'h0, e3.err});
                end
            end
            if (!if3.flush && if3.in_valid && if3.in_ready)
                q3.push_back(model({32'h0, if3.src_data}, if3.imm_ext, if3.a_sel, if3.b_sel, if3.b_imm_en, 3));
            if (if3.flush) q3.delete();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, output exp_t e);
        if4.src_data = {$urandom, $urandom, $urandom, $urandom};
        if4.a_sel    = 2'($urandom_range(0, 3));
        if4.b_sel    = 2'($urandom_range(0, 3));
        if4.b_imm_en = 1'($urandom_range(0, 1));
        if4.imm_ext  = $urandom;
        if4.in_valid = v;
        e = model(if4.src_data, if4.imm_ext, if4.a_sel, if4.b_sel, if4.b_imm_en, 4);
    endtask

    task automatic chk_out4(input string name, input exp_t e);
        check({name, "_valid"}, {63'h0, if4.out_valid}, 64'h1);
        check({name, "_a"}, {32'h0, if4.op_a}, {32'h0, e.a});
        check({name, "_b"}, {32'h0, if4.op_b}, {32'h0, e.b});
    endtask

    task automatic chk_state4(input string name, input logic [1:0] occ, input logic ov, input logic ir);
        check({name, "_occ"}, {62'h0, if4.occupancy}, {62'h0, occ});
        check({name, "_out_valid"}, {63'h0, if4.out_valid}, {63'h0, ov});
        check({name, "_in_ready"}, {63'h0, if4.in_ready}, {63'h0, ir});
    endtask

    vec_t vecs[8];
    exp_t p[3];
    exp_t sx[16];
    exp_t tmp;
    int   pops_before;

    initial begin
        vecs[0] = '{0, 2'd2, 2'd1, 1'b0, 32'h0,        32'h33,  32'h22,       1'b0};
        vecs[1] = '{0, 2'd2, 2'd1, 1'b1, 32'hFFFFF800, 32'h33,  32'hFFFFF800, 1'b0};
        vecs[2] = '{0, 2'd0, 2'd3, 1'b0, 32'h0,        32'h11,  32'h44,       1'b0};
        vecs[3] = '{0, 2'd3, 2'd0, 1'b1, 32'h12345678, 32'h44,  32'h12345678, 1'b0};
        vecs[4] = '{1, 2'd3, 2'd0, 1'b0, 32'h0,        32'h0,   32'h11a,      1'b1};
        vecs[5] = '{1, 2'd1, 2'd3, 1'b1, 32'hABCD,     32'h22b, 32'hABCD,     1'b0};
        vecs[6] = '{1, 2'd0, 2'd3, 1'b0, 32'h0,        32'h11a, 32'h0,        1'b1};
        vecs[7] = '{1, 2'd2, 2'd2, 1'b0, 32'h0,        32'h33c, 32'h33c,      1'b0};

        if4.src_data = '0; if4.imm_ext = '0; if4.a_sel = '0; if4.b_sel = '0;
        if4.b_imm_en = 1'b0; if4.in_valid = 1'b0; if4.flush = 1'b0; if4.out_ready = 1'b0;
        if3.src_data = '0; if3.imm_ext = '0; if3.a_sel = '0; if3.b_sel = '0;
        if3.b_imm_en = 1'b0; if3.in_valid = 1'b0; if3.flush = 1'b0; if3.out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_state4("reset", 2'd0, 1'b0, 1'b1);
        check("reset_op_a", {32'h0, if4.op_a}, 64'h0);
        check("reset_op_b", {32'h0, if4.op_b}, 64'h0);
        check("reset_err", {63'h0, if4.sel_err}, 64'h0);
        check("reset3_valid", {63'h0, if3.out_valid}, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table on both instances.
        if4.out_ready = 1'b1;
        if4.src_data  = {32'h44, 32'h33, 32'h22, 32'h11};
        if3.src_data  = {32'h33c, 32'h22b, 32'h11a};
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].dut == 0) begin
                if4.a_sel = vecs[i].a_sel; if4.b_sel = vecs[i].b_sel;
                if4.b_imm_en = vecs[i].b_imm_en; if4.imm_ext = vecs[i].imm; if4.in_valid = 1'b1;
            end else begin
                if3.a_sel = vecs[i].a_sel; if3.b_sel = vecs[i].b_sel;
                if3.b_imm_en = vecs[i].b_imm_en; if3.imm_ext = vecs[i].imm; if3.in_valid = 1'b1;
            end
            cyc();
            if4.in_valid = 1'b0;
            if3.in_valid = 1'b0;
            if (vecs[i].dut == 0) begin
                check($sformatf("vec%0d_valid", i), {63'h0, if4.out_valid}, 64'h1);
                check($sformatf("vec%0d_a", i), {32'h0, if4.op_a}, {32'h0, vecs[i].exp_a});
                check($sformatf("vec%0d_b", i), {32'h0, if4.op_b}, {32'h0, vecs[i].exp_b});
                check($sformatf("vec%0d_err", i), {63'h0, if4.sel_err}, {63'h0, vecs[i].exp_err});
            end else begin
                check($sformatf("vec%0d_valid", i), {63'h0, if3.out_valid}, 64'h1);
                check($sformatf("vec%0d_a", i), {32'h0, if3.op_a}, {32'h0, vecs[i].exp_a});
                check($sformatf("vec%0d_b", i), {32'h0, if3.op_b}, {32'h0, vecs[i].exp_b});
                check($sformatf("vec%0d_err", i), {63'h0, if3.sel_err}, {63'h0, vecs[i].exp_err});
            end
            cyc();
        end

        // Back-pressure: two accepted, third held until the consumer drains.
        if4.out_ready = 1'b0;
        drive4(1'b1, p[0]);
        cyc();
        chk_state4("bp_one", 2'd1, 1'b1, 1'b1);
        drive4(1'b1, p[1]);
        cyc();
        drive4(1'b1, p[2]);
        for (int k = 0; k < 3; k++) begin
            chk_state4($sformatf("bp_full%0d", k), 2'd2, 1'b1, 1'b0);
            chk_out4($sformatf("bp_hold%0d", k), p[0]);
            cyc();
        end
        if4.out_ready = 1'b1;
        cyc();
        chk_out4("bp_drain1", p[1]);
        chk_state4("bp_drain1", 2'd1, 1'b1, 1'b1);
        cyc();
        if4.in_valid = 1'b0;
        chk_out4("bp_drain2", p[2]);
        cyc();
        chk_state4("bp_empty", 2'd0, 1'b0, 1'b1);

        // Streaming: one pair per cycle.
        pops_before = pops4;
        for (int k = 0; k < 16; k++) begin
            drive4(1'b1, sx[k]);
            cyc();
            chk_out4($sformatf("stream%0d", k), sx[k]);
            check($sformatf("stream%0d_in_ready", k), {63'h0, if4.in_ready}, 64'h1);
        end
        if4.in_valid = 1'b0;
        cyc();
        cyc();
        check("stream_pop_count", 64'(pops4 - pops_before), 64'd16);

        // Flush from TWO, then flush from ONE with a concurrent accept.
        if4.out_ready = 1'b0;
        drive4(1'b1, tmp);
        cyc();
        drive4(1'b1, tmp);
        cyc();
        chk_state4("fl_pre", 2'd2, 1'b1, 1'b0);
        drive4(1'b1, tmp);
        if4.flush = 1'b1;
        cyc();
        if4.flush = 1'b0;
        chk_state4("fl_two", 2'd0, 1'b0, 1'b1);
        drive4(1'b1, tmp);
        cyc();
        drive4(1'b1, tmp);
        if4.flush = 1'b1;
        cyc();
        if4.flush = 1'b0;
        chk_state4("fl_one", 2'd0, 1'b0, 1'b1);
        drive4(1'b1, p[0]);
        if4.out_ready = 1'b1;
        cyc();
        if4.in_valid = 1'b0;
        chk_out4("fl_after", p[0]);
        cyc();
        chk_state4("fl_drained", 2'd0, 1'b0, 1'b1);

        // Asynchronous reset between clock edges.
        drive4(1'b1, tmp);
        cyc();
        drive4(1'b1, tmp);
        #2 rst_n = 1'b0;
        #1;
        if4.in_valid = 1'b0;
        chk_state4("arst", 2'd0, 1'b0, 1'b1);
        check("arst_op_a", {32'h0, if4.op_a}, 64'h0);
        check("arst_op_b", {32'h0, if4.op_b}, 64'h0);
        check("arst_err", {63'h0, if4.sel_err}, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive4(1'b1, p[1]);
        cyc();
        if4.in_valid = 1'b0;
        chk_out4("arst_first", p[1]);
        cyc();
        chk_state4("arst_done", 2'd0, 1'b0, 1'b1);

        cyc();
        check("sb4_leftover", 64'(q4.size()), 64'd0);
        check("sb3_leftover", 64'(q3.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered, parametrised operand-select stage between the register-file/immediate path and the ALU. Each cycle it picks operand A from one of `NUM_SRC` sources and operand B from one of `NUM_SRC` sources or the extended immediate. The selected pair is captured into a 2-entry skid buffer with valid/ready handshakes on both sides. This is the pipelined, multi-source successor of the single-cycle two-input operand-B mux. It gives full throughput under back-pressure, plus a flush and a select-range check.

## Interface
- `DATA_W`, 32, operand width in bits.
- `NUM_SRC`, 4, number of data sources (register read ports plus forwarding paths); any value ≥ 2.
- `SEL_W`, `$clog2(NUM_SRC)`, select width; derived, not overridden.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_data` in `NUM_SRC*DATA_W`: source `i` occupies bits `[i*DATA_W +: DATA_W]`.
- `imm_ext` in `DATA_W`: extended immediate.
- `a_sel` in `SEL_W`: source index for operand A.
- `b_sel` in `SEL_W`: source index for operand B.
- `b_imm_en` in 1: 1 selects `imm_ext` for B and ignores `b_sel` (ALUSrc).
- `in_valid` in 1: upstream offers a selection this cycle.
- `in_ready` out 1: stage can accept this cycle.
- `flush` in 1: synchronous discard of all held entries.
- `out_valid` out 1: `op_a`/`op_b` hold a valid pair.
- `out_ready` in 1: ALU consumes the pair this cycle.
- `op_a` out `DATA_W`: registered operand A.
- `op_b` out `DATA_W`: registered operand B.
- `sel_err` out 1: registered with the pair; 1 if the used `a_sel`/`b_sel` was ≥ `NUM_SRC`.
- `occupancy` out 2: entries held, 0..2.

## Operation
- Selection is combinational on the input side. A = `src[a_sel]`. B = `b_imm_en ? imm_ext : src[b_sel]`.
- An out-of-range select yields 0 for that operand and sets `sel_err` for that entry. `b_sel` is not checked when `b_imm_en`=1.
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- Storage: main register (drives outputs) and skid register. States: EMPTY (0 entries), ONE (main full), TWO (main and skid full).
- EMPTY: accept → ONE, main ← input.
- ONE:
  - accept & pop → ONE, main ← input.
  - accept & !pop → TWO, skid ← input.
  - pop & !accept → EMPTY.
  - neither → ONE, hold.
- TWO: accept is impossible. Pop → ONE, main ← skid. Otherwise hold.
- `in_ready` = (state != TWO). It is a pure function of registered state, with no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY). `occupancy` = 0/1/2 per state.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- `flush`=1: next state is EMPTY regardless of accept/pop. Flush dominates a simultaneous accept, which is discarded. Data registers may keep stale values; `out_valid` is 0.
- `op_a`/`op_b`/`sel_err` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (`rst_n`=0, asynchronous): state EMPTY, `out_valid`=0, `op_a`=0, `op_b`=0, `sel_err`=0, `occupancy`=0, skid data 0, `in_ready`=1.
- Reset release is synchronous to `clk`. The first accept is possible on the first rising edge with `rst_n`=1.
- Latency: a pair accepted at edge N is on `op_a`/`op_b` with `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: 1 pair/cycle while `out_ready`=1.
- With `out_ready` held at 0, exactly 2 pairs are accepted. `in_ready` falls the cycle after the second accept.
- Flush takes effect at the edge where it is sampled. The cycle after, `out_valid`=0 and `in_ready`=1.
- Asserting `rst_n`=0 mid-operation discards all entries immediately, without waiting for a clock edge.

## Test plan
- Basic path, `NUM_SRC`=4. Stimulus: src = {0x44,0x33,0x22,0x11} (src0=0x11), `a_sel`=2, `b_sel`=1, `b_imm_en`=0, one accept. Required: next cycle `out_valid`=1, `op_a`=0x33, `op_b`=0x22. Repeat with `b_imm_en`=1, `imm_ext`=0xFFFFF800 → `op_b`=0xFFFFF800.
- Back-pressure. Stimulus: `out_ready`=0, stream pairs P0,P1,P2 with `in_valid`=1. Required: P0 and P1 accepted; `in_ready`=0 and `occupancy`=2 from the cycle after P1; P2 held off. Then `out_ready`=1: outputs P0, P1, P2 on consecutive cycles with none lost.
- Streaming. Stimulus: 16 back-to-back pairs with `out_ready`=1. Required: 16 outputs on 16 consecutive cycles, in order; `in_ready` stays 1.
- Select range, `NUM_SRC`=3. Stimulus: `a_sel`=3. Required: `op_a`=0 and `sel_err`=1. Stimulus: `b_sel`=3 with `b_imm_en`=1. Required: `sel_err`=0.
- Flush. Stimulus: state TWO, then `flush`=1 together with `in_valid`=1. Required: next cycle `occupancy`=0, `out_valid`=0, `in_ready`=1; the flushed and concurrent pairs never appear at the output.
- Async reset. Stimulus: drop `rst_n` mid-stream between clock edges. Required: `out_valid`, `op_a`, `op_b`, `sel_err` go to 0 immediately; after release, the first accepted pair appears with 1-cycle latency.
